// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS core: sequences PC, IR, memory,
// ALU and register file, with a mem_ready wait timeout and a sticky fault report.
module mips_multicycle_ctrl #(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       JR_Control_sig,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [1:0] ALU_Op,
   output logic       SignZero,
   output logic [3:0] state_out,
   output logic       fault,
   output logic [1:0] fault_code
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_RTEXEC = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11,
      S_JUMP   = 4'd12,
      S_JREG   = 4'd13,
      S_FAULT  = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   // r_cnt holds low cycles already waited, so the current low cycle is the
   // WAIT_LIMIT-th one when r_cnt reaches WAIT_LIMIT-1.
   localparam logic [CNT_W-1:0] W_LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

   state_t           r_state;
   state_t           w_next;
   logic [5:0]       r_opcode;
   logic [CNT_W-1:0] r_cnt;
   logic             r_fault;
   logic [1:0]       r_fault_code;
   logic [1:0]       w_fault_code;
   logic             w_mem_state;
   logic             w_timeout;

   assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   assign w_timeout   = w_mem_state && !mem_ready && (r_cnt == W_LIMIT_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opcode <= 6'd0;
      end else if (r_state == S_DECODE) begin
         r_opcode <= opcode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_mem_state && !mem_ready && (w_next == r_state)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   // Only the first fault is recorded; FAULT never exits except through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault      <= 1'b0;
         r_fault_code <= 2'b00;
      end else if (!r_fault && (w_next == S_FAULT)) begin
         r_fault      <= 1'b1;
         r_fault_code <= w_fault_code;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_fault_code = 2'b00;
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      MemtoReg     = 1'b0;
      RegDst       = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      PCSource     = 2'b00;
      ALU_Op       = 2'b00;
      SignZero     = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_next = S_FETCH;
         end
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) begin
               w_next = S_DECODE;
            end else if (w_timeout) begin
               w_next       = S_FAULT;
               w_fault_code = 2'b01;
            end
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (opcode)
               OP_RTYPE:        w_next = S_RTEXEC;
               OP_LW, OP_SW:    w_next = S_MEMADR;
               OP_BEQ:          w_next = S_BRANCH;
               OP_ADDI, OP_ORI: w_next = S_IEXEC;
               OP_J:            w_next = S_JUMP;
               default: begin
                  w_next       = S_FAULT;
                  w_fault_code = 2'b10;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            w_next  = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               w_next = S_MEMWB;
            end else if (w_timeout) begin
               w_next       = S_FAULT;
               w_fault_code = 2'b01;
            end
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            w_next   = S_FETCH;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               w_next = S_FETCH;
            end else if (w_timeout) begin
               w_next       = S_FAULT;
               w_fault_code = 2'b01;
            end
         end
         S_RTEXEC: begin
            ALUSrcA = 1'b1;
            ALU_Op  = 2'b10;
            w_next  = JR_Control_sig ? S_JREG : S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            w_next   = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALU_Op      = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            w_next      = S_FETCH;
         end
         S_IEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (r_opcode == OP_ORI) begin
               ALU_Op   = 2'b11;
               SignZero = 1'b0;
            end
            w_next = S_IWB;
         end
         S_IWB: begin
            RegWrite = 1'b1;
            w_next   = S_FETCH;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            w_next   = S_FETCH;
         end
         S_JREG: begin
            PCWrite  = 1'b1;
            PCSource = 2'b11;
            w_next   = S_FETCH;
         end
         S_FAULT: begin
            w_next = S_FAULT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign state_out  = r_state;
   assign fault      = r_fault;
   assign fault_code = r_fault_code;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction-level bench: a generator expands instructions into
// per-cycle expected control words; a monitor checks them against the DUT.
module tb_mips_multicycle_ctrl;

   localparam int WAIT_LIMIT = 15;

   localparam int K_LW = 0, K_SW = 1, K_RT = 2, K_BEQ = 3, K_ADDI = 4, K_ORI = 5, K_J = 6, K_ILL = 7;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       jr_sig;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, SignZero, fault;
   logic [1:0] ALUSrcB, PCSource, ALU_Op, fault_code;
   logic [3:0] state_out;

   mips_multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .JR_Control_sig(jr_sig),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_Op(ALU_Op), .SignZero(SignZero),
      .state_out(state_out), .fault(fault), .fault_code(fault_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [5:0]  opc;
      logic        jr;
      logic        mr;
      logic        drop;
      logic [23:0] exp;
      logic [23:0] exp_late;
   } stim_t;

   typedef struct {
      logic [23:0] exp;
      logic        late;
      logic [23:0] exp_late;
   } sb_t;

   stim_t      stim_q[$];
   sb_t        sb_q[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc_no = 0;
   bit         drv_done = 0;
   logic [1:0] g_code = 2'b00;
   int         n_instr = 0;

   // Expected control word for one cycle, taken straight from the per-state table.
   function automatic logic [23:0] ctrl_word(int st, logic mr, bit ori, logic [1:0] code);
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, sz, flt;
      logic [1:0] srcb, pcs, aop, fc;
      pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0; rdst = 0;
      rw = 0; srca = 0; sz = 1; srcb = 0; pcs = 0; aop = 0;
      case (st)
         1:  begin mrd = 1; srcb = 2'b01; pcw = mr; irw = mr; end
         2:  srcb = 2'b11;
         3:  begin srca = 1; srcb = 2'b10; end
         4:  begin mrd = 1; iord = 1; end
         5:  begin rw = 1; m2r = 1; end
         6:  begin mwr = 1; iord = 1; end
         7:  begin srca = 1; aop = 2'b10; end
         8:  begin rw = 1; rdst = 1; end
         9:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         10: begin srca = 1; srcb = 2'b10; if (ori) begin aop = 2'b11; sz = 0; end end
         11: rw = 1;
         12: begin pcw = 1; pcs = 2'b10; end
         13: begin pcw = 1; pcs = 2'b11; end
         default: ;
      endcase
      flt = (st == 14);
      fc  = (st == 14) ? code : 2'b00;
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcs, aop, sz, 4'(st), flt, fc};
   endfunction

   function automatic logic [5:0] op_of(int k);
      case (k)
         K_LW:   return 6'b100011;
         K_SW:   return 6'b101011;
         K_RT:   return 6'b000000;
         K_BEQ:  return 6'b000100;
         K_ADDI: return 6'b001000;
         K_ORI:  return 6'b001101;
         default: return 6'b000010;
      endcase
   endfunction

   function automatic bit legal_op(logic [5:0] op);
      for (int k = 0; k < 7; k++) if (op_of(k) == op) return 1;
      return 0;
   endfunction

   task automatic cyc(int st, logic mr, logic [5:0] opc, logic jr, bit ori, logic rst, bit drop);
      stim_t s;
      s.rst = rst; s.opc = opc; s.jr = jr; s.mr = mr; s.drop = drop;
      s.exp      = ctrl_word(st, mr, ori, g_code);
      s.exp_late = ctrl_word(0, 1'b0, 0, 2'b00);
      stim_q.push_back(s);
   endtask

   // Cycle whose unused inputs are randomized; the DUT must ignore them.
   task automatic cyc_r(int st);
      cyc(st, 1'($urandom), 6'($urandom), 1'($urandom), 0, 1'b1, 0);
   endtask

   task automatic do_reset();
      g_code = 2'b00;
      cyc(0, 1'($urandom), 6'($urandom), 1'($urandom), 0, 1'b0, 0);
      cyc(0, 1'($urandom), 6'($urandom), 1'($urandom), 0, 1'b0, 0);
      cyc_r(0);
   endtask

   task automatic mem_phase(int st, int d, output bit flt);
      flt = 0;
      if (d >= WAIT_LIMIT) begin
         for (int i = 0; i < WAIT_LIMIT; i++) cyc(st, 1'b0, 6'($urandom), 1'($urandom), 0, 1'b1, 0);
         g_code = 2'b01;
         flt = 1;
      end else begin
         for (int i = 0; i < d; i++) cyc(st, 1'b0, 6'($urandom), 1'($urandom), 0, 1'b1, 0);
         cyc(st, 1'b1, 6'($urandom), 1'($urandom), 0, 1'b1, 0);
      end
   endtask

   task automatic fault_tail();
      int n;
      n = 2 + int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) cyc_r(14);
      do_reset();
   endtask

   // Expands one instruction into its expected cycle sequence, starting in FETCH.
   task automatic instr(int k, int fd, int md, logic jr, logic [5:0] ill_op);
      bit flt;
      logic [5:0] op;
      op = (k == K_ILL) ? ill_op : op_of(k);
      n_instr++;
      $display("[TB] instr %0d kind=%0d op=%b fetch_wait=%0d mem_wait=%0d jr=%0b", n_instr, k, op, fd, md, jr);
      mem_phase(1, fd, flt);
      if (flt) begin fault_tail(); return; end
      cyc(2, 1'($urandom), op, 1'($urandom), 0, 1'b1, 0);
      case (k)
         K_LW: begin
            cyc_r(3);
            mem_phase(4, md, flt);
            if (!flt) cyc_r(5);
         end
         K_SW: begin
            cyc_r(3);
            mem_phase(6, md, flt);
         end
         K_RT: begin
            cyc(7, 1'($urandom), 6'($urandom), jr, 0, 1'b1, 0);
            cyc_r(jr ? 13 : 8);
         end
         K_BEQ:  cyc_r(9);
         K_ADDI: begin cyc(10, 1'($urandom), 6'($urandom), 1'($urandom), 0, 1'b1, 0); cyc_r(11); end
         K_ORI:  begin cyc(10, 1'($urandom), 6'($urandom), 1'($urandom), 1, 1'b1, 0); cyc_r(11); end
         K_J:    cyc_r(12);
         default: begin g_code = 2'b10; flt = 1; end
      endcase
      if (flt) fault_tail();
   endtask

   // lw whose write-back cycle is cut short by an asynchronous reset.
   task automatic lw_drop();
      n_instr++;
      $display("[TB] instr %0d lw with reset dropped in MEMWB", n_instr);
      cyc(1, 1'b1, 6'($urandom), 1'($urandom), 0, 1'b1, 0);
      cyc(2, 1'($urandom), op_of(K_LW), 1'($urandom), 0, 1'b1, 0);
      cyc_r(3);
      cyc(4, 1'b1, 6'($urandom), 1'($urandom), 0, 1'b1, 0);
      cyc(5, 1'($urandom), 6'($urandom), 1'($urandom), 0, 1'b1, 1);
      cyc(0, 1'($urandom), 6'($urandom), 1'($urandom), 0, 1'b0, 0);
      cyc_r(0);
   endtask

   function automatic int rnd_delay();
      if ($urandom_range(0, 24) == 0) return WAIT_LIMIT;
      return int'($urandom_range(0, 3));
   endfunction

   // Generator + driver
   initial begin
      int k;
      logic [5:0] ill;
      rst_n = 1'b0; opcode = 6'd0; jr_sig = 1'b0; mem_ready = 1'b0;

      do_reset();
      instr(K_LW, 0, 0, 0, 6'd0);
      instr(K_LW, 0, 0, 0, 6'd0);
      instr(K_RT, 0, 0, 0, 6'd0);
      instr(K_RT, 0, 0, 1, 6'd0);
      instr(K_ORI, 0, 0, 0, 6'd0);
      instr(K_BEQ, 0, 0, 0, 6'd0);
      instr(K_ADDI, 1, 0, 0, 6'd0);
      instr(K_J, 0, 0, 0, 6'd0);
      instr(K_SW, 0, 3, 0, 6'd0);
      instr(K_LW, WAIT_LIMIT - 1, WAIT_LIMIT - 1, 0, 6'd0);
      instr(K_LW, WAIT_LIMIT, 0, 0, 6'd0);
      instr(K_ILL, 0, 0, 0, 6'b111111);
      lw_drop();
      instr(K_SW, 0, WAIT_LIMIT, 0, 6'd0);
      for (int n = 0; n < 70; n++) begin
         if ($urandom_range(0, 99) < 5) k = K_ILL;
         else k = int'($urandom_range(0, 6));
         do ill = 6'($urandom); while (legal_op(ill));
         instr(k, rnd_delay(), rnd_delay(), 1'($urandom), ill);
      end

      while (stim_q.size() > 0) begin
         stim_t s;
         sb_t   e;
         s = stim_q.pop_front();
         @(posedge clk);
         #1;
         rst_n = s.rst; opcode = s.opc; jr_sig = s.jr; mem_ready = s.mr;
         e.exp = s.exp; e.late = s.drop; e.exp_late = s.exp_late;
         sb_q.push_back(e);
         if (s.drop) begin
            @(negedge clk);
            #2;
            rst_n = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      drv_done = 1;
   end

   function automatic logic [23:0] actual_word();
      return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
              RegWrite, ALUSrcA, ALUSrcB, PCSource, ALU_Op, SignZero, state_out, fault, fault_code};
   endfunction

   // Monitor: one control word per cycle, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            sb_t e;
            logic [23:0] act;
            e = sb_q.pop_front();
            cyc_no++;
            act = actual_word();
            tests++;
            if (act !== e.exp) begin
               fails++;
               $display("FAIL cyc%0d ctrl_word: got %h (state %0d) expected %h (state %0d)",
                        cyc_no, act, act[6:3], e.exp, e.exp[6:3]);
            end
            if (e.late) begin
               #3;
               act = actual_word();
               tests++;
               if (act !== e.exp_late) begin
                  fails++;
                  $display("FAIL cyc%0d async_reset_word: got %h expected %h", cyc_no, act, e.exp_late);
               end
            end
         end
      end
   end

   initial begin
      wait (drv_done);
      @(negedge clk);
      #4;
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
